// File: rtl/rst_seq.sv
// Reset sequencer: holds three downstream reset domains in reset after any
// reset cause, waits for a filtered PLL lock, then releases the domains one
// at a time (bit 0 first, bit 2 last) with a fixed stagger between them.
module rst_seq #(
  parameter int STRETCH_CYC = 16,
  parameter int LOCK_FILTER = 4,
  parameter int STAGGER_CYC = 8
) (
  input  logic       i_in_clk,
  input  logic       i_rst_async_n,
  input  logic       i_pll_locked,
  input  logic       i_soft_rst_req,
  output logic [2:0] o_rst_out,
  output logic       o_soft_rst_ack,
  output logic       o_rst_done
);

  // One shared counter serves every timed state, so size it for the largest period.
  localparam int MAX_AB  = (STRETCH_CYC > LOCK_FILTER) ? STRETCH_CYC : LOCK_FILTER;
  localparam int MAX_CYC = (MAX_AB > STAGGER_CYC) ? MAX_AB : STAGGER_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL0      = 3'd2,
    ST_REL1      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  logic             lock_meta_reg;
  logic             lock_s_reg;
  logic             req_samp_reg;
  logic             req_prev_reg;
  logic             req_rise;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       rst_out_reg;
  logic [2:0]       rst_out_next;
  logic             ack_reg;
  logic             ack_next;
  logic             done_reg;
  logic             done_next;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge i_in_clk or negedge i_rst_async_n) begin
    if (!i_rst_async_n) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= i_pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  // Sample the soft request, then keep a delayed copy for rising-edge detection.
  always_ff @(posedge i_in_clk or negedge i_rst_async_n) begin
    if (!i_rst_async_n) begin
      req_samp_reg <= 1'b0;
      req_prev_reg <= 1'b0;
    end else begin
      req_samp_reg <= i_soft_rst_req;
      req_prev_reg <= req_samp_reg;
    end
  end

  // A held request only counts once; a new one needs a low sample in between.
  assign req_rise = req_samp_reg & ~req_prev_reg;

  // State, counter and registered outputs; reset forces all domains into reset.
  always_ff @(posedge i_in_clk or negedge i_rst_async_n) begin
    if (!i_rst_async_n) begin
      state_reg   <= ST_ASSERT;
      cnt_reg     <= '0;
      rst_out_reg <= 3'b111;
      ack_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rst_out_reg <= rst_out_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they change
  // on the same edge as the state they belong to.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    if (req_rise) begin
      // Soft request wins over everything and also covers a coincident lock loss.
      state_next = ST_ASSERT;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          // Lock is deliberately ignored while stretching.
          if (cnt_reg == STRETCH_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Count consecutive lock-high cycles; any low cycle restarts the filter.
          if (!lock_s_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == LOCK_LAST) begin
            state_next = ST_REL0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_REL0: begin
          if (!lock_s_reg) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
          end else if (cnt_reg == STAGGER_LAST) begin
            state_next = ST_REL1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_REL1: begin
          if (!lock_s_reg) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
          end else if (cnt_reg == STAGGER_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          cnt_next = '0;
          if (!lock_s_reg) begin
            state_next = ST_ASSERT;
          end
        end
        default: begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode: release order is fixed by the state order, so the bits can
  // only fall 0 -> 1 -> 2 and always rise together on re-entry to ASSERT.
  always_comb begin
    rst_out_next = 3'b111;
    done_next    = 1'b0;
    ack_next     = req_rise;
    case (state_next)
      ST_REL0: rst_out_next = 3'b110;
      ST_REL1: rst_out_next = 3'b100;
      ST_RUN: begin
        rst_out_next = 3'b000;
        done_next    = 1'b1;
      end
      default: rst_out_next = 3'b111;
    endcase
  end

  assign o_rst_out      = rst_out_reg;
  assign o_soft_rst_ack = ack_reg;
  assign o_rst_done     = done_reg;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter STRETCH_CYC, default 16, meaning the number of cycles all resets are held after any reset cause (legal range 2..1023).
REQ-002 SHALL have parameter LOCK_FILTER, default 4, meaning the number of consecutive cycles of synchronized lock high required before release begins (legal range 1..255).
REQ-003 SHALL have parameter STAGGER_CYC, default 8, meaning the number of cycles between successive domain releases (legal range 1..1023).
REQ-004 SHALL have port i_in_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_async_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_pll_locked, input, 1 bit: PLL lock, asynchronous to i_in_clk.
REQ-007 SHALL have port i_soft_rst_req, input, 1 bit: software reset request (level); each rising edge is one request.
REQ-008 SHALL have port o_rst_out, output, 3 bits: active-high reset per downstream domain; each bit feeds that domain's reset synchronizer.
REQ-009 SHALL have port o_soft_rst_ack, output, 1 bit: one-cycle acknowledge of an accepted soft request.
REQ-010 SHALL have port o_rst_done, output, 1 bit: high only when all domains are released.

Function
REQ-011 SHALL synchronize i_pll_locked through 2 flops (lock_s) and edge-detect i_soft_rst_req with a registered copy (req_rise); both are used only after synchronization.
REQ-012 SHALL implement FSM states ASSERT, WAIT_LOCK, REL0, REL1, RUN, with a shared cycle counter wide enough for the largest parameter.
REQ-013 ASSERT: o_rst_out=3'b111 and o_rst_done=0; SHALL remain exactly STRETCH_CYC cycles, then go to WAIT_LOCK; lock_s is ignored in this state.
REQ-014 WAIT_LOCK: SHALL count consecutive cycles with lock_s=1; a cycle with lock_s=0 clears the count; on the LOCK_FILTER-th consecutive high cycle, SHALL go to REL0 and drive o_rst_out[0]=0 from that edge.
REQ-015 REL0: o_rst_out=3'b110; after STAGGER_CYC cycles SHALL go to REL1 and drive o_rst_out[1]=0.
REQ-016 REL1: o_rst_out=3'b100; after STAGGER_CYC cycles SHALL go to RUN and drive o_rst_out[2]=0 and o_rst_done=1 on the same edge.
REQ-017 In WAIT_LOCK excluded, lock_s=0 in REL0, REL1 or RUN SHALL move the FSM to ASSERT with the counter cleared, so o_rst_out=3'b111 and o_rst_done=0 on the next edge.
REQ-018 A req_rise in any state SHALL move the FSM to ASSERT with the counter cleared and SHALL pulse o_soft_rst_ack for exactly one cycle on that same edge; a req_rise while already in ASSERT restarts the stretch.
REQ-019 A request held high SHALL produce exactly one ack; a new request requires a low cycle first.
REQ-020 Simultaneous req_rise and lock loss SHALL be treated as one cause: the FSM goes to ASSERT and the ack pulses.
REQ-021 All outputs SHALL be registered; o_rst_out bits SHALL never deassert out of order (bit 0, then 1, then 2) and SHALL assert together.
REQ-022 The counter SHALL saturate or clear on each state change; it never wraps within a state.

Reset
REQ-023 While i_rst_async_n=0: o_rst_out=3'b111 immediately (asynchronously), o_rst_done=0, o_soft_rst_ack=0, state=ASSERT, counter=0, sync and edge flops=0.
REQ-024 Reset assertion mid-operation SHALL override every state at once; after release, the full sequence restarts from ASSERT.
REQ-025 With defaults and lock stable high, edges are counted from the first rising edge after reset release (edge 1): o_rst_out[0] falls at edge 20, [1] at edge 28, [2] and o_rst_done rise/fall at edge 36.

Verification
REQ-026 Defaults, lock high, reset release: o_rst_out 111 -> 110 at edge 20 -> 100 at edge 28 -> 000 and done=1 at edge 36.
REQ-027 Lock low until edge 30, then high: release of [0] occurs exactly LOCK_FILTER=4 cycles after lock_s rises; a 1-cycle lock glitch in WAIT_LOCK restarts the 4-cycle count.
REQ-028 In RUN, pulse i_soft_rst_req high 5 cycles: exactly one ack cycle, o_rst_out=111 next edge, done=0, full sequence repeats (16+4+8+8 cycles).
REQ-029 In REL1, drop i_pll_locked: o_rst_out returns to 111 within 3 edges (2 sync + 1), sequence restarts after lock returns.
REQ-030 Assert i_rst_async_n=0 mid-REL0 between clock edges: o_rst_out=111 without a clock edge; ack, done=0.
REQ-031 Soft request rising on the same edge as lock loss in RUN: one ack pulse, single ASSERT entry, stretch of 16 cycles.
